// File: rtl/fsm_if.sv
// Serial detector bus: one input bit stream and the registered match flag.
// FSM_HIT_COUNT_EN adds the saturating 8-bit match counter.
interface fsm_if;
  logic       ins;
  logic       outs;
`ifdef FSM_HIT_COUNT_EN
  logic [7:0] hit_count;

  modport master (output ins, input  outs, input  hit_count);
  modport slave  (input  ins, output outs, output hit_count);
`else
  modport master (output ins, input  outs);
  modport slave  (input  ins, output outs);
`endif
endinterface

// File: rtl/fsm.sv
// Moore serial pattern detector (KMP prefix-length states, tables built at elaboration).
// Optional FSM_HIT_COUNT_EN adds a saturating match counter on the bus.
module fsm #(
  parameter int                   PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  fsm_if.slave bus
);

  localparam int SW = $clog2(PAT_WIDTH + 1);
  localparam int NS = 1 << SW;

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, then b).
  function automatic int next_len(input int k, input int b);
    int pat;
    int seq;
    int res;
    pat = int'(PATTERN);
    seq = ((pat >> (PAT_WIDTH - k)) << 1) | b;
    res = 0;
    for (int j = 1; j <= k + 1; j++)
      if ((seq & ((1 << j) - 1)) == (pat >> (PAT_WIDTH - j)))
        res = j;
    return res;
  endfunction

  function automatic int border();
    int pat;
    int res;
    pat = int'(PATTERN);
    res = 0;
    for (int j = 1; j < PAT_WIDTH; j++)
      if ((pat & ((1 << j) - 1)) == (pat >> (PAT_WIDTH - j)))
        res = j;
    return res;
  endfunction

  localparam int F = OVERLAP ? border() : 0;

  typedef enum logic [SW-1:0] {
    S0    = '0,
    MATCH = SW'(PAT_WIDTH)
  } state_t;

  state_t        state;
  state_t        nxt;
  logic          outs_q;
  logic          exp_tbl  [NS];
  logic [SW-1:0] hit_tbl  [NS];
  logic [SW-1:0] miss_tbl [NS];

  // MATCH behaves as S(F); unused encodings recover through S0.
  for (genvar g = 0; g < NS; g++) begin : g_tbl
    localparam int K  = (g == PAT_WIDTH) ? F : ((g > PAT_WIDTH) ? 0 : g);
    localparam int EB = (int'(PATTERN) >> (PAT_WIDTH - 1 - K)) & 1;
    localparam int HN = next_len(K, EB);
    localparam int MN = next_len(K, 1 - EB);
    assign exp_tbl[g]  = EB[0];
    assign hit_tbl[g]  = SW'(HN);
    assign miss_tbl[g] = SW'(MN);
  end

  // An unknown ins fails the equality and takes the fallback path.
  always_comb begin
    nxt = S0;
    if (bus.ins == exp_tbl[state])
      nxt = state_t'(hit_tbl[state]);
    else
      nxt = state_t'(miss_tbl[state]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S0;
      outs_q <= 1'b0;
    end else begin
      state  <= nxt;
      outs_q <= (nxt == MATCH);
    end
  end

  assign bus.outs = outs_q;

`ifdef FSM_HIT_COUNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] hit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hit_q <= 8'd0;
    else if (nxt == MATCH)
      hit_q <= sat_inc(hit_q);
  end

  assign bus.hit_count = hit_q;
`endif

endmodule

// File: tb/tb_fsm.sv
// Bench for fsm: overlapping and non-overlapping instances fed the same stream,
// checked against a sliding-window reference model (FSM_HIT_COUNT_EN aware).
module tb_fsm;

  logic clk;
  logic reset;

  fsm_if bus_o ();
  fsm_if bus_n ();

  fsm #(.PAT_WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_ov (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_o)
  );

  fsm #(.PAT_WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_nov (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  int         len_o;
  int         len_n;
  int         cnt_o;
  int         cnt_n;
  int         pulses_o;
  int         pulses_n;
  logic [3:0] win;
  logic       exp_o;
  logic       exp_n;

  task automatic model_clear();
    win   = 4'd0;
    len_o = 0;
    len_n = 0;
    cnt_o = 0;
    cnt_n = 0;
  endtask

  task automatic check_bit(input string tag, input logic got, input logic want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%b expected=%b at t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic check_cnt(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, want, $time);
    end
  endtask

  // Drive one bit, let the rising edge sample it, compare at the falling edge.
  task automatic send(input logic b);
    logic mb;
    bus_o.ins = b;
    bus_n.ins = b;
    @(posedge clk);
    mb    = (b === 1'b1);
    win   = {win[2:0], mb};
    len_o = len_o + 1;
    len_n = len_n + 1;
    exp_o = (len_o >= 4) && (win == 4'b1011);
    exp_n = (len_n >= 4) && (win == 4'b1011);
    if (exp_n) len_n = 0;
    if (exp_o && cnt_o < 255) cnt_o++;
    if (exp_n && cnt_n < 255) cnt_n++;
    @(negedge clk);
    check_bit("outs_ov", bus_o.outs, exp_o);
    check_bit("outs_nov", bus_n.outs, exp_n);
`ifdef FSM_HIT_COUNT_EN
    check_cnt("hits_ov", int'(bus_o.hit_count), cnt_o);
    check_cnt("hits_nov", int'(bus_n.hit_count), cnt_n);
`endif
    if (bus_o.outs === 1'b1) pulses_o++;
    if (bus_n.outs === 1'b1) pulses_n++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    pulses_o = 0;
    pulses_n = 0;
  endtask

  task automatic run_seq(input string tag, input logic [15:0] bits, input int n,
                         input int want_o, input int want_n);
    logic [15:0] sh;
    do_reset();
    sh = bits << (16 - n);
    for (int i = 0; i < n; i++) begin
      send(sh[15]);
      sh = sh << 1;
    end
    check_cnt({tag, "_pulses_ov"}, pulses_o, want_o);
    check_cnt({tag, "_pulses_nov"}, pulses_n, want_n);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    pulses_o = 0;
    pulses_n = 0;
    model_clear();
    reset     = 1'b1;
    bus_o.ins = 1'b0;
    bus_n.ins = 1'b0;

    // Reset held across two edges while ins toggles.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bus_o.ins = ~bus_o.ins;
      bus_n.ins = bus_o.ins;
      @(posedge clk);
      @(negedge clk);
      check_bit("rst_outs_ov", bus_o.outs, 1'b0);
      check_bit("rst_outs_nov", bus_n.outs, 1'b0);
`ifdef FSM_HIT_COUNT_EN
      check_cnt("rst_hits", int'(bus_o.hit_count), 0);
`endif
    end
    reset = 1'b0;
    model_clear();

    // First edge after reset samples normally: 1011 right away.
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    check_bit("first_match", bus_o.outs, 1'b1);

    // Reset mid-match drops outs without a clock edge.
    reset = 1'b1;
    #1;
    check_bit("async_drop_ov", bus_o.outs, 1'b0);
    check_bit("async_drop_nov", bus_n.outs, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();

    run_seq("basic",   16'b001011,         6,  1, 1);
    run_seq("overlap", 16'b1011011,        7,  2, 1);
    run_seq("stream",  16'b00101110111010, 14, 2, 2);
    run_seq("nearmis", 16'b101011,         6,  1, 1);

    // Unknown bit right after reset is a mismatch; detection still works.
    do_reset();
    send(1'bx);
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    check_cnt("x_pulses", pulses_o, 1);

    // Random stream, lightly seeded with the pattern to raise the hit rate.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
      end else begin
        send(1'($urandom_range(0, 1)));
      end
    end

`ifdef FSM_HIT_COUNT_EN
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    end
    check_cnt("sat_ov", int'(bus_o.hit_count), 255);
    check_cnt("sat_nov", int'(bus_n.hit_count), 255);
    reset = 1'b1;
    #1;
    check_cnt("sat_clear", int'(bus_o.hit_count), 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
